speck_iter_core: RTL and testbench
==================================

Name: speck_iter_core

Overview:
- Parametrised, iterative SPECK block-cipher engine covering the 2N/mN family (SPECK-32 through SPECK-128); one round per clock.
- Supports both encryption and decryption, selected per block.
- Uses a valid/ready handshake on input and output, with output back-pressure.
- Sits downstream of the key-schedule block, which supplies all round keys on a flat bus, and replaces the fixed SPECK-32 encrypt-only engine.

Parameters:
- WORD, 16, word size N in bits (16, 24, 32, 48, 64); block is 2*WORD bits.
- ROUNDS, 22, number of rounds T (22 for 32/64, 27 for 64/128, 34 for 128/256).
- ALPHA, (WORD==16 ? 7 : 8), right-rotate amount applied to x.
- BETA, (WORD==16 ? 2 : 3), left-rotate amount applied to y.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- in_valid  in  1  din/mode valid.
- in_ready  out  1  core can accept a block.
- mode  in  1  0 = encrypt, 1 = decrypt; sampled on input handshake.
- din  in  2*WORD  input block {x,y}; x = din[2W-1:W], y = din[W-1:0].
- round_keys  in  WORD*ROUNDS  key i at [WORD*i+WORD-1 : WORD*i].
- out_valid  out  1  dout holds a completed block.
- out_ready  in  1  downstream accepts dout.
- dout  out  2*WORD  result block {x,y}.
- busy  out  1  high from accept until output handshake.

Behaviour:
- Reset (reset==0 at a clock edge):
  - state=IDLE, round counter=0, x/y registers=0.
  - dout=0, out_valid=0, busy=0.
  - in_ready=0 while reset is low; in_ready=1 on the first cycle after release.
  - Reset overrides everything, including mid-RUN and DONE; the in-flight block is discarded with no output.
- States:
  - IDLE: in_ready=1, busy=0.
  - RUN: in_ready=0, busy=1.
  - DONE: in_ready=0, busy=1, out_valid=1.
- IDLE -> RUN on in_valid & in_ready: latch {x,y}=din, latch mode, round counter=0.
- RUN: one round per cycle, with key index k = counter (encrypt) or ROUNDS-1-counter (decrypt).
  - Encrypt round: x' = (ROR(x,ALPHA) + y) ^ K; y' = ROL(y,BETA) ^ x'.
  - Decrypt round: y' = ROR(y ^ x, BETA); x' = ROL((x ^ K) - y', ALPHA).
  - Add/subtract are modulo 2^WORD; rotates are within WORD bits.
  - Counter increments each RUN cycle; on the cycle applying the last round (counter==ROUNDS-1): go to DONE, load dout with {x',y'}, set out_valid=1.
- Latency: accept at edge E; out_valid=1 after edge E+ROUNDS.
- DONE: dout and out_valid hold stable until out_ready=1 at an edge; then out_valid=0, busy=0, -> IDLE. in_ready becomes 1 the following cycle.
- No block is accepted in RUN/DONE; in_valid there is ignored and has no effect on the block in flight.
- round_keys are not latched. The source must hold them stable from accept until out_valid; changing them mid-RUN corrupts only the current block.
- mode is latched, so changing mode during RUN has no effect.
- Counter width is $clog2(ROUNDS); no wrap occurs because the counter resets on each accept.
- dout is 0 after reset and otherwise holds the last result until the next completion.

Test Plan:
- SPECK-32/64 encrypt:
  - Stimulus: WORD=16, ROUNDS=22, round keys from the bench model's expansion of key 1918 1110 0908 0100, din=6574694c, mode=0.
  - Required: dout=a86842f2; out_valid rises exactly 22 cycles after accept; busy high throughout.
- SPECK-32/64 decrypt:
  - Stimulus: same keys, din=a86842f2, mode=1.
  - Required: dout=6574694c after 22 cycles.
- SPECK-64/128 encrypt:
  - Stimulus: WORD=32, ROUNDS=27, key 1b1a1918 13121110 0b0a0908 03020100, din=3b7265747475432d.
  - Required: dout=8c6fa548454e028b after 27 cycles.
- Back-pressure and protocol:
  - Stimulus: hold out_ready=0 for 10 cycles after out_valid, toggling in_valid and din meanwhile.
  - Required: dout stable, out_valid=1, in_ready=0, no new accept. After out_ready pulse: out_valid=0 and in_ready=1 the next cycle; the second block encrypts correctly.
- Reset mid-operation:
  - Stimulus: assert reset low at round 10 of a block.
  - Required: next cycle out_valid=0, busy=0, dout=0, in_ready=0. After release, in_ready=1; a fresh block gives the correct result with nominal latency.
- Random round-trip:
  - Stimulus: 200 random keys and blocks, encrypt then decrypt.
  - Required: plaintext recovered, and encrypt output matches the bench reference model.

Source files
------------

// File: rtl/speck_iter_core_if.sv
// Handshake and data bundle between a SPECK block source/sink and speck_iter_core.
// The master modport is the side that drives blocks and keys and consumes results.
interface speck_iter_core_if #(
    parameter int WORD   = 16,
    parameter int ROUNDS = 22
);
    logic                     in_valid;
    logic                     in_ready;
    logic                     mode;
    logic [2*WORD-1:0]        din;
    logic [WORD*ROUNDS-1:0]   round_keys;
    logic                     out_valid;
    logic                     out_ready;
    logic [2*WORD-1:0]        dout;
    logic                     busy;

    modport master (
        output in_valid, mode, din, round_keys, out_ready,
        input  in_ready, out_valid, dout, busy
    );

    modport slave (
        input  in_valid, mode, din, round_keys, out_ready,
        output in_ready, out_valid, dout, busy
    );
endinterface

// File: rtl/speck_iter_core.sv
// Iterative SPECK 2N/mN encrypt/decrypt engine, one round per clock.
// Latency: accept at edge E, out_valid after edge E+ROUNDS; result holds in DONE until out_ready.
module speck_iter_core #(
    parameter int WORD   = 16,
    parameter int ROUNDS = 22,
    parameter int ALPHA  = (WORD == 16) ? 7 : 8,
    parameter int BETA   = (WORD == 16) ? 2 : 3
) (
    input  logic              clock,
    input  logic              reset,
    speck_iter_core_if.slave  bus
);
    localparam int CW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]          r_state;
    logic [CW-1:0]       r_cnt;
    logic                r_mode;
    logic [WORD-1:0]     r_x;
    logic [WORD-1:0]     r_y;
    logic [2*WORD-1:0]   r_dout;

    logic [WORD-1:0]     w_rk [ROUNDS];
    logic [CW-1:0]       w_kidx;
    logic [WORD-1:0]     w_key;
    logic [WORD-1:0]     w_ex;
    logic [WORD-1:0]     w_ey;
    logic [WORD-1:0]     w_dt;
    logic [WORD-1:0]     w_dy;
    logic [WORD-1:0]     w_ds;
    logic [WORD-1:0]     w_dx;
    logic [WORD-1:0]     w_nx;
    logic [WORD-1:0]     w_ny;
    logic                w_last;

    genvar gi;
    generate
        for (gi = 0; gi < ROUNDS; gi++) begin : g_rk
            assign w_rk[gi] = bus.round_keys[WORD*gi +: WORD];
        end
    endgenerate

    // Decryption walks the key schedule backwards with the same up-counter.
    assign w_kidx = r_mode ? (CW'(ROUNDS - 1) - r_cnt) : r_cnt;
    assign w_key  = w_rk[w_kidx];
    assign w_last = (r_cnt == CW'(ROUNDS - 1));

    assign w_ex = (((r_x >> ALPHA) | (r_x << (WORD - ALPHA))) + r_y) ^ w_key;
    assign w_ey = ((r_y << BETA) | (r_y >> (WORD - BETA))) ^ w_ex;

    assign w_dt = r_y ^ r_x;
    assign w_dy = (w_dt >> BETA) | (w_dt << (WORD - BETA));
    assign w_ds = (r_x ^ w_key) - w_dy;
    assign w_dx = (w_ds << ALPHA) | (w_ds >> (WORD - ALPHA));

    assign w_nx = r_mode ? w_dx : w_ex;
    assign w_ny = r_mode ? w_dy : w_ey;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_mode  <= 1'b0;
            r_x     <= '0;
            r_y     <= '0;
            r_dout  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_x     <= bus.din[2*WORD-1:WORD];
                        r_y     <= bus.din[WORD-1:0];
                        r_mode  <= bus.mode;
                        r_cnt   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_x <= w_nx;
                    r_y <= w_ny;
                    if (w_last) begin
                        r_dout  <= {w_nx, w_ny};
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Gated by the reset pin so the core never advertises ready while held in reset.
    assign bus.in_ready  = (r_state == S_IDLE) && reset;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.dout      = r_dout;
endmodule

// File: tb/tb_speck_iter_core.sv
// Bench for speck_iter_core: SPECK-32/64 instance checked every cycle against a behavioural model,
// plus a SPECK-64/128 instance for the wider known-answer vector.
module tb_speck_iter_core;
    localparam int KW = 64 * 34;

    logic clock;
    logic reset;

    int errs   = 0;
    int checks = 0;

    speck_iter_core_if #(.WORD(16), .ROUNDS(22)) b16 ();
    speck_iter_core_if #(.WORD(32), .ROUNDS(27)) b32 ();

    speck_iter_core #(.WORD(16), .ROUNDS(22)) u16 (.clock(clock), .reset(reset), .bus(b16));
    speck_iter_core #(.WORD(32), .ROUNDS(27)) u32 (.clock(clock), .reset(reset), .bus(b32));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- SPECK reference arithmetic ----------------
    function automatic logic [63:0] msk(input int w);
        return (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    endfunction

    function automatic logic [63:0] rotr(input logic [63:0] v, input int r, input int w);
        return ((v >> r) | (v << (w - r))) & msk(w);
    endfunction

    function automatic logic [63:0] rotl(input logic [63:0] v, input int r, input int w);
        return rotr(v, w - r, w);
    endfunction

    function automatic logic [KW-1:0] expand(input int w, input int rounds,
                                             input logic [63:0] l2, input logic [63:0] l1,
                                             input logic [63:0] l0, input logic [63:0] k0);
        logic [63:0]   l [64];
        logic [63:0]   k;
        logic [KW-1:0] keys;
        int a, b;
        a = (w == 16) ? 7 : 8;
        b = (w == 16) ? 2 : 3;
        l[0] = l0; l[1] = l1; l[2] = l2;
        k = k0;
        keys = '0;
        for (int i = 0; i < rounds; i++) begin
            keys = keys | (KW'(k) << (w * i));
            if (i < rounds - 1) begin
                l[i+3] = ((k + rotr(l[i], a, w)) & msk(w)) ^ 64'(i);
                k = rotl(k, b, w) ^ l[i+3];
            end
        end
        return keys;
    endfunction

    function automatic logic [127:0] speck_model(input int w, input int rounds, input logic [127:0] blk,
                                                 input bit dec, input logic [KW-1:0] keys);
        logic [63:0] x, y, k;
        int a, b, j;
        a = (w == 16) ? 7 : 8;
        b = (w == 16) ? 2 : 3;
        x = 64'(blk >> w) & msk(w);
        y = blk[63:0] & msk(w);
        for (int i = 0; i < rounds; i++) begin
            j = dec ? (rounds - 1 - i) : i;
            k = 64'(keys >> (w * j)) & msk(w);
            if (!dec) begin
                x = ((rotr(x, a, w) + y) & msk(w)) ^ k;
                y = rotl(y, b, w) ^ x;
            end else begin
                y = rotr(y ^ x, b, w);
                x = rotl(((x ^ k) - y) & msk(w), a, w);
            end
        end
        return ({64'd0, x} << w) | {64'd0, y};
    endfunction

    // ---------------- cycle model of the 16-bit instance ----------------
    bit            m_known = 0;
    bit            m_run   = 0;
    bit            m_done  = 0;
    int            m_cnt   = 0;
    logic [127:0]  m_res;
    logic [31:0]   m_dout  = '0;

    always @(posedge clock) begin
        if (!reset) begin
            m_known = 1; m_run = 0; m_done = 0; m_dout = '0;
        end else if (m_known) begin
            if (m_run) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_run  = 0;
                    m_done = 1;
                    m_dout = m_res[31:0];
                end
            end else if (m_done) begin
                if (b16.out_ready) m_done = 0;
            end else if (b16.in_valid) begin
                m_res = speck_model(16, 22, b16.din, b16.mode, b16.round_keys);
                m_cnt = 22;
                m_run = 1;
            end
        end
    end

    always begin
        @(negedge clock);
        #1;
        if (m_known) begin
            chk("in_ready", b16.in_ready, reset && !m_run && !m_done);
            chk("busy",     b16.busy,     m_run || m_done);
            chk("out_valid", b16.out_valid, m_done);
            chk("dout",     b16.dout,     m_dout);
        end
    end

    // ---------------- drivers ----------------
    task automatic wait_ready16();
        int t = 0;
        while (!b16.in_ready && t < 50) begin
            @(negedge clock);
            t++;
        end
        chk("in_ready16 wait", t < 50, 1);
    endtask

    task automatic run16(input logic [31:0] blk, input bit dec, input int hold,
                         output logic [31:0] res, output int lat);
        wait_ready16();
        b16.din = blk; b16.mode = dec; b16.in_valid = 1'b1;
        @(negedge clock);
        b16.in_valid = 1'b0;
        lat = 0;
        while (!b16.out_valid && lat < 200) begin
            b16.in_valid = 1'($urandom_range(0, 1));
            b16.din      = $urandom;
            b16.mode     = 1'($urandom_range(0, 1));
            @(negedge clock);
            lat++;
        end
        res = b16.dout;
        for (int i = 0; i < hold; i++) begin
            b16.in_valid = 1'($urandom_range(0, 1));
            b16.din      = $urandom;
            @(negedge clock);
            chk("hold dout", b16.dout, res);
        end
        b16.in_valid  = 1'b0;
        b16.out_ready = 1'b1;
        @(negedge clock);
        b16.out_ready = 1'b0;
    endtask

    task automatic run32(input logic [63:0] blk, input bit dec, output logic [63:0] res, output int lat);
        int t = 0;
        while (!b32.in_ready && t < 50) begin
            @(negedge clock);
            t++;
        end
        chk("in_ready32 wait", t < 50, 1);
        b32.din = blk; b32.mode = dec; b32.in_valid = 1'b1;
        @(negedge clock);
        b32.in_valid = 1'b0;
        b32.mode     = ~dec;
        lat = 0;
        while (!b32.out_valid && lat < 200) begin
            chk("busy32", b32.busy, 1);
            @(negedge clock);
            lat++;
        end
        res = b32.dout;
        b32.out_ready = 1'b1;
        @(negedge clock);
        b32.out_ready = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [KW-1:0]  kf;
        logic [127:0]   mr;
        logic [31:0]    r16, pt, ct;
        logic [63:0]    r32;
        logic [63:0]    kk;
        int             lat;

        reset = 1'b0;
        b16.in_valid = 0; b16.mode = 0; b16.din = '0; b16.out_ready = 0; b16.round_keys = '0;
        b32.in_valid = 0; b32.mode = 0; b32.din = '0; b32.out_ready = 0; b32.round_keys = '0;

        repeat (3) @(negedge clock);
        #1;
        chk("rst in_ready16", b16.in_ready, 0);
        chk("rst out_valid32", b32.out_valid, 0);
        chk("rst busy32", b32.busy, 0);
        chk("rst dout32", b32.dout, 0);
        reset = 1'b1;
        #1;
        chk("release in_ready16", b16.in_ready, 1);
        chk("release in_ready32", b32.in_ready, 1);

        // SPECK-32/64 known answer
        kf = expand(16, 22, 64'h1918, 64'h1110, 64'h0908, 64'h0100);
        b16.round_keys = kf[16*22-1:0];
        mr = speck_model(16, 22, 128'h6574694c, 0, kf);
        chk("model enc32/64", mr, 128'ha86842f2);
        run16(32'h6574694c, 0, 0, r16, lat);
        chk("enc32/64 dout", r16, 32'ha86842f2);
        chk("enc32/64 latency", lat, 22);
        run16(32'ha86842f2, 1, 0, r16, lat);
        chk("dec32/64 dout", r16, 32'h6574694c);
        chk("dec32/64 latency", lat, 22);

        // SPECK-64/128 known answer
        kf = expand(32, 27, 64'h1b1a1918, 64'h13121110, 64'h0b0a0908, 64'h03020100);
        b32.round_keys = kf[32*27-1:0];
        mr = speck_model(32, 27, 128'h3b7265747475432d, 0, kf);
        chk("model enc64/128", mr, 128'h8c6fa548454e028b);
        run32(64'h3b7265747475432d, 0, r32, lat);
        chk("enc64/128 dout", r32, 64'h8c6fa548454e028b);
        chk("enc64/128 latency", lat, 27);
        run32(64'h8c6fa548454e028b, 1, r32, lat);
        chk("dec64/128 dout", r32, 64'h3b7265747475432d);

        // back-pressure then a second block
        run16(32'h6574694c, 0, 10, r16, lat);
        chk("bp dout", r16, 32'ha86842f2);
        chk("bp after in_ready", b16.in_ready, 1);
        run16(32'h6574694c, 0, 0, r16, lat);
        chk("bp second dout", r16, 32'ha86842f2);

        // reset at round 10
        wait_ready16();
        b16.din = 32'h6574694c; b16.mode = 0; b16.in_valid = 1;
        @(negedge clock);
        b16.in_valid = 0;
        repeat (10) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        #1;
        chk("midrst out_valid", b16.out_valid, 0);
        chk("midrst busy", b16.busy, 0);
        chk("midrst dout", b16.dout, 0);
        chk("midrst in_ready", b16.in_ready, 0);
        reset = 1'b1;
        #1;
        chk("midrst release in_ready", b16.in_ready, 1);
        run16(32'h6574694c, 0, 0, r16, lat);
        chk("post-rst dout", r16, 32'ha86842f2);
        chk("post-rst latency", lat, 22);

        // random round trips
        for (int n = 0; n < 200; n++) begin
            kk = {$urandom, $urandom};
            kf = expand(16, 22, 64'(kk[63:48]), 64'(kk[47:32]), 64'(kk[31:16]), 64'(kk[15:0]));
            b16.round_keys = kf[16*22-1:0];
            pt = $urandom;
            mr = speck_model(16, 22, 128'(pt), 0, kf);
            run16(pt, 0, $urandom_range(0, 3), ct, lat);
            chk("rand enc", ct, mr[31:0]);
            run16(ct, 1, $urandom_range(0, 3), r16, lat);
            chk("rand roundtrip", r16, pt);
        end

        repeat (2) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
